// File: rtl/ab_mon_pkg.sv
// Shared types and helpers for the A-implies-eventually-B monitor:
// channel state encoding, population count and saturating counter update.
package ab_mon_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } state_t;

   localparam int unsigned MAX_CH = 32;
   localparam int unsigned INC_W  = 6;   // clog2(MAX_CH + 1)
   localparam int unsigned SUM_W  = 64;

   // Elapsed-counter width: enough to hold MAX_WAIT, never narrower than one bit.
   function automatic int unsigned el_width(input int unsigned max_wait);
      int unsigned w;
      w = (max_wait == 0) ? 1 : $clog2(max_wait + 1);
      return (w < 1) ? 1 : w;
   endfunction

   function automatic logic [INC_W-1:0] popcount(input logic [MAX_CH-1:0] v);
      logic [INC_W-1:0] n;
      n = '0;
      for (int unsigned i = 0; i < MAX_CH; i++) begin
         n = n + INC_W'(v[i]);
      end
      return n;
   endfunction

   // Adds inc to cur and clamps the result at 2^w - 1.
   function automatic logic [SUM_W-1:0] sat_add(input logic [SUM_W-1:0] cur,
                                                input logic [INC_W-1:0] inc,
                                                input int unsigned      w);
      logic [SUM_W-1:0] lim;
      logic [SUM_W-1:0] sum;
      lim = (SUM_W'(1) << w) - SUM_W'(1);
      sum = cur + SUM_W'(inc);
      return (sum > lim) ? lim : sum;
   endfunction

endpackage

// File: rtl/ab_mon_chan.sv
// One monitored A/B channel: tracks the oldest open obligation and issues
// registered pass/fail pulses; next-cycle pulses are exported for the counters.
module ab_mon_chan
   import ab_mon_pkg::*;
#(
   parameter int unsigned MAX_WAIT = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic a,
   input  logic b,
   input  logic eot,
   output logic pend,
   output logic pass_p,
   output logic fail_p,
   output logic pass_d,
   output logic fail_d
);

   localparam int unsigned      EL_W   = el_width(MAX_WAIT);
   localparam logic [EL_W-1:0]  EL_LIM = EL_W'(MAX_WAIT);
   localparam logic             TIMED  = (MAX_WAIT != 0);

   state_t          state;
   state_t          state_d;
   logic [EL_W-1:0] el;
   logic [EL_W-1:0] el_d;

   always_comb begin
      state_d = state;
      el_d    = el;
      pass_d  = 1'b0;
      fail_d  = 1'b0;
      if (!en) begin
         state_d = ST_IDLE;
         el_d    = '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (a) begin
                  state_d = ST_WAIT;
                  el_d    = '0;
               end
            end
            ST_WAIT: begin
               // B wins over flush and timeout; a same-edge A opens a fresh obligation.
               if (b) begin
                  pass_d  = 1'b1;
                  state_d = a ? ST_WAIT : ST_IDLE;
                  el_d    = '0;
               end else if (eot) begin
                  fail_d  = 1'b1;
                  state_d = ST_IDLE;
                  el_d    = '0;
               end else if (TIMED && (el + EL_W'(1) == EL_LIM)) begin
                  fail_d  = 1'b1;
                  state_d = a ? ST_WAIT : ST_IDLE;
                  el_d    = '0;
               end else if (el != '1) begin
                  el_d = el + EL_W'(1);
               end
            end
            default: begin
               state_d = ST_IDLE;
               el_d    = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= ST_IDLE;
         el     <= '0;
         pass_p <= 1'b0;
         fail_p <= 1'b0;
      end else begin
         state  <= state_d;
         el     <= el_d;
         pass_p <= pass_d;
         fail_p <= fail_d;
      end
   end

   assign pend = (state == ST_WAIT);

endmodule

// File: rtl/ab_eventually_monitor.sv
// Multi-channel "A implies eventually B" liveness monitor with optional
// deadline, end-of-test flush, saturating verdict counters and sticky error.
module ab_eventually_monitor
   import ab_mon_pkg::*;
#(
   parameter int unsigned N_CH     = 4,
   parameter int unsigned MAX_WAIT = 8,
   parameter int unsigned CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [N_CH-1:0]  a,
   input  logic [N_CH-1:0]  b,
   input  logic             eot,
   output logic [N_CH-1:0]  pend,
   output logic [N_CH-1:0]  pass_p,
   output logic [N_CH-1:0]  fail_p,
   output logic [CNT_W-1:0] pass_cnt,
   output logic [CNT_W-1:0] fail_cnt,
   output logic             err_sticky
);

   logic [N_CH-1:0]  pass_d;
   logic [N_CH-1:0]  fail_d;
   logic [SUM_W-1:0] pass_sum;
   logic [SUM_W-1:0] fail_sum;

   for (genvar g = 0; g < N_CH; g++) begin : g_chan
      ab_mon_chan #(
         .MAX_WAIT(MAX_WAIT)
      ) u_chan (
         .clk   (clk),
         .rst   (rst),
         .en    (en),
         .a     (a[g]),
         .b     (b[g]),
         .eot   (eot),
         .pend  (pend[g]),
         .pass_p(pass_p[g]),
         .fail_p(fail_p[g]),
         .pass_d(pass_d[g]),
         .fail_d(fail_d[g])
      );
   end

   // Counting next-cycle pulses keeps the counters aligned with the visible pulses.
   always_comb begin
      pass_sum = sat_add(SUM_W'(pass_cnt), popcount(MAX_CH'(pass_d)), CNT_W);
      fail_sum = sat_add(SUM_W'(fail_cnt), popcount(MAX_CH'(fail_d)), CNT_W);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pass_cnt   <= '0;
         fail_cnt   <= '0;
         err_sticky <= 1'b0;
      end else begin
         pass_cnt   <= CNT_W'(pass_sum);
         fail_cnt   <= CNT_W'(fail_sum);
         err_sticky <= err_sticky | (|fail_d);
      end
   end

endmodule
